// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU: single-cycle logic/arith plus iterative unsigned MULU/DIVU behind valid/ready.
// Optional overflow output is built only when ALU_OVERFLOW_EN is defined.
module alu_mc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MULU = 4'b0011;
    localparam logic [3:0] OP_DIVU = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic             is_mul_q;
    logic [WIDTH-1:0] acc_q, wrk_q, opd_q;
    logic [CW-1:0]    cnt_q;

    logic             accept_c, multi_c, last_c;
    logic [WIDTH-1:0] sum_c, diff_c, sc_res_c, sc_hi_c;
    logic [WIDTH-1:0] step_acc_c, step_wrk_c;
    logic [WIDTH:0]   mul_sum_c, div_sh_c, div_diff_c;
`ifdef ALU_OVERFLOW_EN
    logic             sc_ovf_c;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept_c  = in_valid & in_ready;
    // DIVU by zero is resolved immediately and never enters the iterative path
    assign multi_c   = (alu_control == OP_MULU) || ((alu_control == OP_DIVU) && (b != '0));
    assign last_c    = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_c) state_nxt = multi_c ? BUSY : DONE;
            BUSY:    if (last_c) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Single-cycle result, taken straight from the request operands
    always_comb begin
        sum_c    = a + b;
        diff_c   = a - b;
        sc_res_c = '0;
        sc_hi_c  = '0;
        case (alu_control)
            OP_AND:  sc_res_c = a & b;
            OP_OR:   sc_res_c = a | b;
            OP_ADD:  sc_res_c = sum_c;
            OP_SUB:  sc_res_c = diff_c;
            OP_SLT:  sc_res_c = WIDTH'($signed(a) < $signed(b));
            OP_SLTU: sc_res_c = WIDTH'(a < b);
            OP_DIVU: begin
                sc_res_c = '1;
                sc_hi_c  = a;
            end
            default: ;
        endcase
    end

`ifdef ALU_OVERFLOW_EN
    always_comb begin
        sc_ovf_c = 1'b0;
        if (alu_control == OP_ADD)
            sc_ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
        else if (alu_control == OP_SUB)
            sc_ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff_c[WIDTH-1] != a[WIDTH-1]);
    end
`endif

    // One iteration: {acc,wrk} is the product (MULU) or {remainder,quotient} (DIVU)
    always_comb begin
        mul_sum_c  = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, opd_q} : '0);
        div_sh_c   = {acc_q, wrk_q[WIDTH-1]};
        div_diff_c = div_sh_c - {1'b0, opd_q};
        step_acc_c = '0;
        step_wrk_c = '0;
        if (is_mul_q) begin
            step_acc_c = mul_sum_c[WIDTH:1];
            step_wrk_c = {mul_sum_c[0], wrk_q[WIDTH-1:1]};
        end else if (!div_diff_c[WIDTH]) begin
            step_acc_c = div_diff_c[WIDTH-1:0];
            step_wrk_c = {wrk_q[WIDTH-2:0], 1'b1};
        end else begin
            step_acc_c = div_sh_c[WIDTH-1:0];
            step_wrk_c = {wrk_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result   <= '0;
            hi       <= '0;
            zero     <= 1'b1;
            is_mul_q <= 1'b0;
            acc_q    <= '0;
            wrk_q    <= '0;
            opd_q    <= '0;
            cnt_q    <= '0;
`ifdef ALU_OVERFLOW_EN
            overflow <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (accept_c) begin
                    if (multi_c) begin
                        is_mul_q <= (alu_control == OP_MULU);
                        acc_q    <= '0;
                        wrk_q    <= (alu_control == OP_MULU) ? b : a;
                        opd_q    <= (alu_control == OP_MULU) ? a : b;
                        cnt_q    <= '0;
                    end else begin
                        result   <= sc_res_c;
                        hi       <= sc_hi_c;
                        zero     <= (sc_res_c == '0);
`ifdef ALU_OVERFLOW_EN
                        overflow <= sc_ovf_c;
`endif
                    end
                end
                BUSY: begin
                    acc_q <= step_acc_c;
                    wrk_q <= step_wrk_c;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_c) begin
                        result   <= step_wrk_c;
                        hi       <= step_acc_c;
                        zero     <= (step_wrk_c == '0);
`ifdef ALU_OVERFLOW_EN
                        overflow <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: a 32-bit and an 8-bit instance share clock and reset.
module tb_alu_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  c0, c1;
    logic [31:0] a0, b0, r0, h0;
    logic [7:0]  a1, b1, r1, h1;
    logic        iv0, ir0, ov0, or0, z0;
    logic        iv1, ir1, ov1, or1, z1;
`ifdef ALU_OVERFLOW_EN
    logic        f0, f1;
`endif

    alu_mc #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .alu_control(c0), .a(a0), .b(b0),
        .in_valid(iv0), .in_ready(ir0), .out_valid(ov0), .out_ready(or0),
        .result(r0), .hi(h0), .zero(z0)
`ifdef ALU_OVERFLOW_EN
        , .overflow(f0)
`endif
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .alu_control(c1), .a(a1), .b(b1),
        .in_valid(iv1), .in_ready(ir1), .out_valid(ov1), .out_ready(or1),
        .result(r1), .hi(h1), .zero(z1)
`ifdef ALU_OVERFLOW_EN
        , .overflow(f1)
`endif
    );

    typedef struct {
        string       tag;
        logic [31:0] r;
        logic [31:0] h;
        logic        ov;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference behaviour at width w, computed arithmetically
    function automatic exp_t model(input string tag, input logic [3:0] c,
                                   input logic [31:0] x, input logic [31:0] y, input int w);
        exp_t        e;
        logic [63:0] mask, p;
        logic        sx, sy, sr;
        mask  = (64'd1 << w) - 64'd1;
        e.tag = tag; e.r = '0; e.h = '0; e.ov = 1'b0; e.lat = 1;
        sx = x[w-1]; sy = y[w-1];
        case (c)
            4'b0000: e.r = x & y;
            4'b0001: e.r = x | y;
            4'b0010: begin
                p = {32'b0, x} + {32'b0, y}; e.r = 32'(p & mask); sr = p[w-1];
                e.ov = (sx == sy) && (sr != sx);
            end
            4'b0110: begin
                p = {32'b0, x} - {32'b0, y}; e.r = 32'(p & mask); sr = p[w-1];
                e.ov = (sx != sy) && (sr != sx);
            end
            4'b0111: e.r = (sx != sy) ? 32'(sx) : 32'(x < y);
            4'b0101: e.r = 32'(x < y);
            4'b0011: begin
                p = {32'b0, x} * {32'b0, y};
                e.r = 32'(p & mask); e.h = 32'(p >> w); e.lat = w + 1;
            end
            4'b0100: begin
                if (y == 0) begin
                    e.r = 32'(mask); e.h = x;
                end else begin
                    e.r = x / y; e.h = x % y; e.lat = w + 1;
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic void sample(input int w, output logic v, output logic rdy, output logic z,
                                   output logic ovf, output logic [31:0] r, output logic [31:0] h);
        ovf = 1'b0;
        if (w == 8) begin
            v = ov1; rdy = ir1; z = z1; r = {24'b0, r1}; h = {24'b0, h1};
`ifdef ALU_OVERFLOW_EN
            ovf = f1;
`endif
        end else begin
            v = ov0; rdy = ir0; z = z0; r = r0; h = h0;
`ifdef ALU_OVERFLOW_EN
            ovf = f0;
`endif
        end
    endfunction

    // Drive one op, wait (bounded) for out_valid, compare against the scoreboard head, then consume
    task automatic run_op(input int w, input string tag, input logic [3:0] c,
                          input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        int          lat;
        logic        v, rdy, z, ovf, busy_ok;
        logic [31:0] r, h;
        sb.push_back(model(tag, c, x, y, w));
        @(negedge clk);
        if (w == 8) begin c1 = c; a1 = x[7:0]; b1 = y[7:0]; iv1 = 1'b1; end
        else        begin c0 = c; a0 = x;      b0 = y;      iv0 = 1'b1; end
        sample(w, v, rdy, z, ovf, r, h);
        chk({tag, "/in_ready"}, 64'(rdy), 64'd1);
        @(posedge clk); #1;
        iv0 = 1'b0; iv1 = 1'b0;
        lat = 1; busy_ok = 1'b1;
        sample(w, v, rdy, z, ovf, r, h);
        while (v !== 1'b1 && lat < 200) begin
            if (rdy !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
            sample(w, v, rdy, z, ovf, r, h);
        end
        e = sb.pop_front();
        chk({e.tag, "/latency"}, 64'(lat), 64'(e.lat));
        chk({e.tag, "/result"}, {32'b0, r}, {32'b0, e.r});
        chk({e.tag, "/hi"}, {32'b0, h}, {32'b0, e.h});
        chk({e.tag, "/zero"}, 64'(z), 64'(e.r == 0));
        if (e.lat > 1) chk({e.tag, "/busy_in_ready"}, 64'(busy_ok), 64'd1);
`ifdef ALU_OVERFLOW_EN
        chk({e.tag, "/overflow"}, 64'(ovf), 64'(e.ov));
`endif
        @(negedge clk);
        if (w == 8) or1 = 1'b1; else or0 = 1'b1;
        @(posedge clk); #1;
        or0 = 1'b0; or1 = 1'b0;
        sample(w, v, rdy, z, ovf, r, h);
        chk({e.tag, "/release"}, {62'b0, v, rdy}, 64'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        stable, emitted;
        logic [3:0]  ops [8];
        exp_t        e;
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0011, 4'b0100};

        rst = 1'b1;
        c0 = '0; a0 = '0; b0 = '0; iv0 = 1'b0; or0 = 1'b0;
        c1 = '0; a1 = '0; b1 = '0; iv1 = 1'b0; or1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/out_valid", 64'(ov0), 64'd0);
        chk("reset/in_ready", 64'(ir0), 64'd1);
        chk("reset/zero", 64'(z0), 64'd1);
        chk("reset/result", {32'b0, r0}, 64'd0);
        chk("reset/hi", {32'b0, h0}, 64'd0);
`ifdef ALU_OVERFLOW_EN
        chk("reset/overflow", 64'(f0), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        run_op(32, "add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
        run_op(32, "sub_zero", 4'b0110, 32'd5, 32'd5);
        run_op(32, "slt", 4'b0111, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op(32, "sltu", 4'b0101, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op(32, "and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00);
        run_op(32, "or", 4'b0001, 32'hF000_0001, 32'h0000_1230);
        run_op(32, "sub_ovf", 4'b0110, 32'h8000_0000, 32'h0000_0001);
        run_op(32, "mulu_max", 4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(32, "divu", 4'b0100, 32'd100, 32'd7);
        run_op(32, "divu_by0", 4'b0100, 32'd5, 32'd0);
        run_op(32, "undef", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
        for (int i = 0; i < 6; i++)
            run_op(32, $sformatf("rand%0d", i), ops[$urandom_range(7)], $urandom, $urandom);

        run_op(8, "mulu8", 4'b0011, 32'hFF, 32'h02);
        run_op(8, "undef8", 4'b1111, 32'h5A, 32'h33);
        run_op(8, "divu8", 4'b0100, 32'd200, 32'd9);

        // Backpressure: hold out_ready low in DONE while a competing request is presented
        sb.push_back(model("bp", 4'b0010, 32'd3, 32'd4, 32));
        @(negedge clk);
        c0 = 4'b0010; a0 = 32'd3; b0 = 32'd4; iv0 = 1'b1;
        @(posedge clk); #1;
        c0 = 4'b0110; a0 = 32'd99; b0 = 32'd1;
        e = sb.pop_front();
        stable = 1'b1;
        repeat (10) begin
            if (ov0 !== 1'b1 || r0 !== e.r || h0 !== e.h || ir0 !== 1'b0) stable = 1'b0;
            @(posedge clk); #1;
        end
        chk("bp/stable", 64'(stable), 64'd1);
        chk("bp/result", {32'b0, r0}, {32'b0, e.r});
        iv0 = 1'b0;
        @(negedge clk);
        or0 = 1'b1;
        @(posedge clk); #1;
        or0 = 1'b0;
        chk("bp/idle_next_edge", {62'b0, ov0, ir0}, 64'b01);
        run_op(32, "bp_next", 4'b0110, 32'd99, 32'd1);

        // Reset while DIVU is iterating: nothing may be reported afterwards
        @(negedge clk);
        c0 = 4'b0100; a0 = 32'd100; b0 = 32'd7; iv0 = 1'b1;
        @(posedge clk); #1;
        iv0 = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy/out_valid", 64'(ov0), 64'd0);
        chk("rst_busy/result", {32'b0, r0}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy/in_ready", 64'(ir0), 64'd1);
        chk("rst_busy/zero", 64'(z0), 64'd1);
        emitted = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ov0 !== 1'b0) emitted = 1'b1;
        end
        chk("rst_busy/no_emit", 64'(emitted), 64'd0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
